// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
// Ports: none (package).
// Provides the arbiter FSM state type and the requester-ID width helper.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mul_dual_unit.sv
// Combinational W x W multiplier, unsigned or two's-complement per operation.
// Ports: a, b (W-bit operands), is_signed (1 = two's complement), prod (2W-bit product).
// Latency: zero cycles (pure combinational); no flow control.
module mul_dual_unit #(
  parameter int W = 4
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           is_signed,
  output logic [2*W-1:0] prod
);

  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] b_ext;

  // Extending to 2W bits (sign or zero) and keeping the low 2W bits of the
  // product gives the exact result in both modes, so a single multiplier
  // serves signed and unsigned requests.
  always_comb begin
    a_ext = is_signed ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    b_ext = is_signed ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    prod  = a_ext * b_ext;
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one multiplier among NREQ requesters, one operation in flight.
// Ports: clk/reset (sync, active-high); req_valid/req_ready/req_a/req_b/req_signed request side;
//        rsp_valid/rsp_ready/rsp_prod/rsp_id response side; busy = not IDLE.
// Latency: grant in cycle N -> rsp_valid in N+2; response held until rsp_ready, then next grant.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*W-1:0]           req_a,
  input  logic [NREQ*W-1:0]           req_b,
  input  logic [NREQ-1:0]             req_signed,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [2*W-1:0]              rsp_prod,
  output logic [id_width(NREQ)-1:0]   rsp_id,
  output logic                        busy
);

  localparam int IDW = id_width(NREQ);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] winner;
  logic           found;
  logic           grant;

  logic [W-1:0]   op_a_q;
  logic [W-1:0]   op_b_q;
  logic           op_signed_q;
  logic [IDW-1:0] op_id_q;

  logic [2*W-1:0] prod_comb;
  logic [2*W-1:0] rsp_prod_q;
  logic [IDW-1:0] rsp_id_q;

  // Circular priority search: distance k from rr_ptr is scanned in order, so
  // the first active requester at or after the pointer wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && (((int'(rr_ptr_q) + k) % NREQ) == i)) begin
          found  = 1'b1;
          winner = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    req_ready = '0;
    grant     = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[winner] = 1'b1;
          grant             = 1'b1;
          rr_ptr_d          = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
          state_d           = CALC;
        end
      end
      CALC: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // No grant is offered while reset is being applied.
    if (reset) begin
      req_ready = '0;
    end
  end

  mul_dual_unit #(.W(W)) u_mul (
    .a         (op_a_q),
    .b         (op_b_q),
    .is_signed (op_signed_q),
    .prod      (prod_comb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_signed_q <= 1'b0;
      op_id_q     <= '0;
      rsp_prod_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (grant) begin
        op_a_q      <= req_a[winner*W +: W];
        op_b_q      <= req_b[winner*W +: W];
        op_signed_q <= req_signed[winner];
        op_id_q     <= winner;
      end
      // Result registers load only in CALC, so they stay frozen through RESP.
      if (state_q == CALC) begin
        rsp_prod_q <= prod_comb;
        rsp_id_q   <= op_id_q;
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_prod  = rsp_prod_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_signed;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2*W-1:0]    rsp_prod;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;
  logic [2*W-1:0] obs_prod;
  logic [IDW-1:0] obs_id;

  mul_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_prod   (rsp_prod),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: operands as integers, exact product, low 2W bits.
  function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic s);
    int ia, ib, p;
    ia = int'({1'b0, a});
    ib = int'({1'b0, b});
    if (s && a[W-1]) ia = ia - (1 << W);
    if (s && b[W-1]) ib = ib - (1 << W);
    p = ia * ib;
    return p[2*W-1:0];
  endfunction

  // Reference arbitration: first requester at or after the pointer, circularly.
  function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    reset      = 1'b1;
    req_valid  = '0;
    rsp_ready  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_signed = '0;
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    model_ptr = 0;
  endtask

  // One full transaction starting in IDLE: grant, CALC, RESP held for 'hold'
  // extra cycles, then return to IDLE. Optionally scrambles request inputs
  // after the grant to show they are ignored.
  task automatic run_txn(input logic [NREQ-1:0] vmask, input int hold, input bit scramble);
    int win;
    logic [NREQ-1:0] exp_rdy;
    logic [2*W-1:0]  exp_p;
    logic [IDW-1:0]  exp_id;
    req_valid = vmask;
    rsp_ready = (hold == 0);
    #1;
    win = model_pick(vmask, model_ptr);
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    checks++;
    if (req_ready !== exp_rdy) begin
      errors++;
      $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_rdy);
    end
    if (win < 0) win = 0;
    exp_p  = model_prod(req_a[win*W +: W], req_b[win*W +: W], req_signed[win]);
    exp_id = win[IDW-1:0];
    model_ptr = (win + 1) % NREQ;
    @(posedge clk); #1;
    if (scramble) begin
      req_valid  = 4'($urandom);
      req_a      = 16'($urandom);
      req_b      = 16'($urandom);
      req_signed = 4'($urandom);
      #1;
    end
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== '0) begin
      errors++;
      $display("FAIL calc_cycle: rsp_valid=%b busy=%b req_ready=%b expected 0 1 0000",
               rsp_valid, busy, req_ready);
    end
    @(posedge clk); #1;
    obs_prod = rsp_prod;
    obs_id   = rsp_id;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_prod !== exp_p || rsp_id !== exp_id) begin
      errors++;
      $display("FAIL response: valid=%b prod=%h id=%0d expected 1 %h %0d",
               rsp_valid, rsp_prod, rsp_id, exp_p, exp_id);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_prod !== exp_p || rsp_id !== exp_id || req_ready !== '0) begin
        errors++;
        $display("FAIL hold: valid=%b prod=%h id=%0d req_ready=%b expected 1 %h %0d 0000",
                 rsp_valid, rsp_prod, rsp_id, req_ready, exp_p, exp_id);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_signed = '0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== '0 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_prod !== '0 || rsp_id !== '0) begin
      errors++;
      $display("FAIL reset_values: ready=%b busy=%b valid=%b prod=%h id=%0d expected all zero",
               req_ready, busy, rsp_valid, rsp_prod, rsp_id);
    end
    reset     = 1'b0;
    req_valid = '0;
    model_ptr = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL idle_quiet: busy=%b valid=%b ready=%b expected 0 0 0000",
                 busy, rsp_valid, req_ready);
      end
    end
  endtask

  task automatic test_unsigned();
    req_a = 16'h000D; req_b = 16'h0003; req_signed = 4'b0000;
    run_txn(4'b0001, 0, 0);
    checks++;
    if (obs_prod !== 8'h27 || obs_id !== 2'd0) begin
      errors++;
      $display("FAIL unsigned_D_x_3: prod=%h id=%0d expected 27 0", obs_prod, obs_id);
    end
  endtask

  task automatic test_signed();
    req_a = 16'h0D00; req_b = 16'h0300; req_signed = 4'b0100;
    run_txn(4'b0100, 0, 0);
    checks++;
    if (obs_prod !== 8'hF7 || obs_id !== 2'd2) begin
      errors++;
      $display("FAIL signed_m3_x_3: prod=%h id=%0d expected f7 2", obs_prod, obs_id);
    end
    req_a = 16'h0080; req_b = 16'h0080; req_signed = 4'b0010;
    run_txn(4'b0010, 1, 0);
    checks++;
    if (obs_prod !== 8'h40 || obs_id !== 2'd1) begin
      errors++;
      $display("FAIL signed_m8_x_m8: prod=%h id=%0d expected 40 1", obs_prod, obs_id);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    req_a = 16'($urandom); req_b = 16'($urandom); req_signed = 4'($urandom);
    for (int n = 0; n < 5; n++) begin
      run_txn(4'hF, 0, 0);
      checks++;
      if (int'(obs_id) != exp_seq[n]) begin
        errors++;
        $display("FAIL rr_order[%0d]: id=%0d expected %0d", n, obs_id, exp_seq[n]);
      end
    end
  endtask

  task automatic test_backpressure();
    req_a = 16'h5A3C; req_b = 16'hC3A5; req_signed = 4'b1010;
    run_txn(4'hF, 5, 1);
    req_a = 16'h1234; req_b = 16'h8765;
    run_txn(4'hF, 0, 0);
  endtask

  task automatic test_single();
    for (int n = 0; n < 3; n++) begin
      req_a = 16'($urandom); req_b = 16'($urandom); req_signed = 4'($urandom);
      run_txn(4'b0010, 0, 0);
      checks++;
      if (obs_id !== 2'd1) begin
        errors++;
        $display("FAIL single_req[%0d]: id=%0d expected 1", n, obs_id);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Reset while in CALC (pointer is 3 after granting req2).
    apply_reset();
    req_a = 16'h0700; req_b = 16'h0500;
    req_valid = 4'b0100;
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = 4'hF;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL reset_in_calc: valid=%b busy=%b ready=%b expected 0 0 0000",
               rsp_valid, busy, req_ready);
    end
    reset = 1'b0;
    model_ptr = 0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL ptr_after_calc_reset: req_ready=%b expected 0001", req_ready);
    end
    run_txn(4'hF, 0, 0);
    checks++;
    if (obs_id !== 2'd0) begin
      errors++;
      $display("FAIL grant_after_calc_reset: id=%0d expected 0", obs_id);
    end
    // Reset while in RESP.
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL reach_resp: rsp_valid=%b expected 1", rsp_valid);
    end
    reset = 1'b1;
    req_valid = 4'hF;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_prod !== '0 || rsp_id !== '0) begin
      errors++;
      $display("FAIL reset_in_resp: valid=%b busy=%b prod=%h id=%0d expected 0 0 00 0",
               rsp_valid, busy, rsp_prod, rsp_id);
    end
    reset = 1'b0;
    model_ptr = 0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL ptr_after_resp_reset: req_ready=%b expected 0001", req_ready);
    end
    run_txn(4'hF, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      req_a      = 16'($urandom);
      req_b      = 16'($urandom);
      req_signed = 4'($urandom);
      run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    rsp_ready  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_signed = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_round_robin();
    test_backpressure();
    test_single();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
